// File: rtl/sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_round_ctrl
//  Description : Sequencing controller for the SHA-256 compression datapath.
//                Accepts padded blocks, loads the schedule, steps the rounds,
//                updates/chains the hash state and holds the digest flag
//                until the consumer acknowledges it.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_round_ctrl #(
    parameter int ROUNDS = 64,
    parameter int RW     = 6,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            blk_valid,
    input  logic            blk_last,
    output logic            blk_ready,
    input  logic            pad_ovf,
    output logic            core_load,
    output logic            h_init,
    output logic            core_en,
    output logic [RW-1:0]   round_idx,
    output logic            h_update,
    output logic            digest_valid,
    input  logic            digest_ack,
    output logic            busy,
    output logic            err,
    output logic [CNTW-1:0] blk_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ROUND  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [RW-1:0]   C_LAST_ROUND = RW'(ROUNDS - 1);
    localparam logic [CNTW-1:0] C_CNT_MAX    = {CNTW{1'b1}};

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_first_blk;
    logic            r_last_q;
    logic [RW-1:0]   r_round;
    logic [CNTW-1:0] r_cnt;

    // Ready is a pure state decode so the padder never sees a comb path.
    assign blk_ready = (r_state == S_IDLE);
    assign round_idx = r_round;
    assign blk_cnt   = r_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; an overflow from the padder overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (pad_ovf) begin
            w_state_nxt = S_ERR;
        end else begin
            case (r_state)
                S_IDLE:   if (blk_valid) w_state_nxt = S_LOAD;
                S_LOAD:   w_state_nxt = S_ROUND;
                S_ROUND:  if (r_round == C_LAST_ROUND) w_state_nxt = S_UPDATE;
                S_UPDATE: w_state_nxt = r_last_q ? S_DONE : S_IDLE;
                S_DONE:   if (digest_ack) w_state_nxt = S_IDLE;
                S_ERR:    w_state_nxt = S_ERR;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Registered Moore outputs, computed from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_load    <= 1'b0;
            h_init       <= 1'b0;
            core_en      <= 1'b0;
            h_update     <= 1'b0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            core_load    <= (w_state_nxt == S_LOAD);
            h_init       <= (w_state_nxt == S_LOAD) && r_first_blk;
            core_en      <= (w_state_nxt == S_ROUND);
            h_update     <= (w_state_nxt == S_UPDATE);
            digest_valid <= (w_state_nxt == S_DONE);
            busy         <= (w_state_nxt != S_IDLE);
            err          <= (w_state_nxt == S_ERR);
        end
    end

    // Round index, block counter and message-chaining flags; frozen on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round     <= '0;
            r_cnt       <= '0;
            r_first_blk <= 1'b1;
            r_last_q    <= 1'b0;
        end else if (!pad_ovf) begin
            case (r_state)
                S_IDLE: begin
                    if (blk_valid) r_last_q <= blk_last;
                end
                S_LOAD: begin
                    r_round <= '0;
                end
                S_ROUND: begin
                    // Explicit wrap so ROUNDS below 2^RW still leaves 0 behind.
                    r_round <= (r_round == C_LAST_ROUND) ? '0 : r_round + 1'b1;
                end
                S_UPDATE: begin
                    if (r_cnt != C_CNT_MAX) r_cnt <= r_cnt + 1'b1;
                    r_first_blk <= r_last_q;
                end
                S_DONE: begin
                    if (digest_ack) begin
                        r_cnt       <= '0;
                        r_first_blk <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_round_ctrl
//  Description : Self-checking bench for sha256_round_ctrl: vector table,
//                directed multi-cycle sequences and a random run against a
//                schedule-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_round_ctrl;

    localparam int ROUNDS = 64;
    localparam int RW     = 6;
    localparam int CNTW   = 16;
    localparam int NCYC   = 3000;
    localparam int NARR   = NCYC + ROUNDS + 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            blk_valid = 1'b0;
    logic            blk_last = 1'b0;
    logic            blk_ready;
    logic            pad_ovf = 1'b0;
    logic            core_load;
    logic            h_init;
    logic            core_en;
    logic [RW-1:0]   round_idx;
    logic            h_update;
    logic            digest_valid;
    logic            digest_ack = 1'b0;
    logic            busy;
    logic            err;
    logic [CNTW-1:0] blk_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    sha256_round_ctrl #(.ROUNDS(ROUNDS), .RW(RW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
        .pad_ovf(pad_ovf),
        .core_load(core_load), .h_init(h_init), .core_en(core_en),
        .round_idx(round_idx), .h_update(h_update),
        .digest_valid(digest_valid), .digest_ack(digest_ack),
        .busy(busy), .err(err), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit l, input bit a, input bit o);
        blk_valid  = v;
        blk_last   = l;
        digest_ack = a;
        pad_ovf    = o;
    endtask

    typedef struct {
        bit v, l, a, o;
        bit rdy, ld, hi, en;
        int idx;
        bit upd, dv, bsy, er;
    } vec_t;

    vec_t tbl [10];

    // Schedule of expected events for the random run, indexed by cycle.
    bit e_load  [NARR];
    bit e_hinit [NARR];
    bit e_en    [NARR];
    int e_idx   [NARR];
    bit e_upd   [NARR];

    initial begin
        // inputs v l a o | rdy ld hi en idx | upd dv bsy er
        tbl[0] = '{0,0,0,0, 1,0,0,0,0, 0,0,0,0};  // idle after reset
        tbl[1] = '{0,0,1,0, 1,0,0,0,0, 0,0,0,0};  // stray ack ignored
        tbl[2] = '{1,1,0,0, 1,0,0,0,0, 0,0,0,0};  // handshake
        tbl[3] = '{0,0,0,0, 0,1,1,0,0, 0,0,1,0};  // LOAD with h_init
        tbl[4] = '{1,0,0,0, 0,0,0,1,0, 0,0,1,0};  // round 0, valid back-pressured
        tbl[5] = '{1,0,0,0, 0,0,0,1,1, 0,0,1,0};  // round 1
        tbl[6] = '{0,0,0,1, 0,0,0,1,2, 0,0,1,0};  // overflow during round 2
        tbl[7] = '{0,0,0,0, 0,0,0,0,0, 0,0,1,1};  // ERR
        tbl[8] = '{1,1,1,0, 0,0,0,0,0, 0,0,1,1};  // ERR ignores everything
        tbl[9] = '{0,0,0,0, 0,0,0,0,0, 0,0,1,1};  // ERR is sticky

        // ---------------- reset values (while rst held) ----------------
        #12;
        chk("rst_ready", blk_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_dv", digest_valid, 0);
        chk("rst_load", core_load, 0);
        chk("rst_cnt", blk_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("tbl_ready", blk_ready, tbl[i].rdy);
            chk("tbl_load", core_load, tbl[i].ld);
            chk("tbl_hinit", h_init, tbl[i].hi);
            chk("tbl_en", core_en, tbl[i].en);
            if (tbl[i].en) chk("tbl_idx", round_idx, tbl[i].idx);
            chk("tbl_upd", h_update, tbl[i].upd);
            chk("tbl_dv", digest_valid, tbl[i].dv);
            chk("tbl_busy", busy, tbl[i].bsy);
            chk("tbl_err", err, tbl[i].er);
            chk("tbl_cnt", blk_cnt, 0);
            drive(tbl[i].v, tbl[i].l, tbl[i].a, tbl[i].o);
        end

        // Async reset out of ERR, no clock edge involved.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_err", err, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", blk_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0);

        // ---------------- single block, back-pressure, collision ----------------
        @(negedge clk);
        chk("s1_ready", blk_ready, 1);
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("s1_load", core_load, 1);
        chk("s1_hinit", h_init, 1);
        chk("s1_ready_load", blk_ready, 0);
        for (int k = 0; k < ROUNDS; k++) begin
            @(negedge clk);
            chk("s1_en", core_en, 1);
            chk("s1_idx", round_idx, k);
            chk("s1_noload", core_load, 0);
            chk("s1_bp_ready", blk_ready, 0);
        end
        @(negedge clk);
        chk("s1_upd", h_update, 1);
        chk("s1_en_off", core_en, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("s1_dv_hold", digest_valid, 1);
            chk("s1_cnt", blk_cnt, 1);
            chk("s1_done_ready", blk_ready, 0);
            chk("s1_done_noload", core_load, 0);
        end
        drive(1, 1, 1, 0);
        @(negedge clk);
        chk("col_dv_off", digest_valid, 0);
        chk("col_ready", blk_ready, 1);
        chk("col_cnt", blk_cnt, 0);
        drive(1, 1, 0, 0);
        @(negedge clk);
        chk("col_load", core_load, 1);
        chk("col_hinit", h_init, 1);
        drive(0, 0, 0, 0);

        // ---------------- async reset mid-ROUND at index 37 ----------------
        for (int k = 0; k <= 37; k++) begin
            @(negedge clk);
            chk("ar_idx", round_idx, k);
        end
        #2 rst = 1'b1;
        #1;
        chk("ar_en", core_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ready", blk_ready, 1);
        chk("ar_idx0", round_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 0, 0);
        begin
            int lat;
            @(negedge clk);
            chk("ar2_load", core_load, 1);
            chk("ar2_hinit", h_init, 1);
            drive(0, 0, 0, 0);
            lat = 1;
            while (lat < 200 && !h_update) begin
                @(negedge clk);
                lat++;
            end
            chk("ar2_latency", lat, ROUNDS + 2);
        end
        @(negedge clk);
        chk("ar2_dv", digest_valid, 1);
        drive(0, 0, 1, 0);
        @(negedge clk);
        chk("ar2_dv_off", digest_valid, 0);
        chk("ar2_ready", blk_ready, 1);
        drive(0, 0, 0, 0);

        // ---------------- random run against scheduling model ----------------
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        begin
            int  free_at = 0;
            int  done_at = -1;
            int  cnt     = 0;
            bit  first   = 1'b1;
            bit  exp_rdy, exp_dv, v, l, a;
            for (int c = 0; c < NCYC; c++) begin
                if (c > 0) @(negedge clk);
                exp_rdy = (c >= free_at) && (done_at < 0);
                exp_dv  = (done_at >= 0) && (c >= done_at);
                chk("rnd_ready", blk_ready, exp_rdy);
                chk("rnd_busy", busy, !exp_rdy);
                chk("rnd_load", core_load, e_load[c]);
                chk("rnd_hinit", h_init, e_load[c] & e_hinit[c]);
                chk("rnd_en", core_en, e_en[c]);
                if (e_en[c]) chk("rnd_idx", round_idx, e_idx[c]);
                chk("rnd_upd", h_update, e_upd[c]);
                chk("rnd_dv", digest_valid, exp_dv);
                chk("rnd_cnt", blk_cnt, cnt);
                chk("rnd_err", err, 0);

                v = ($urandom_range(1, 0) == 1);
                l = ($urandom_range(2, 0) == 0);
                a = ($urandom_range(3, 0) == 0);
                drive(v, l, a, 0);

                if (exp_rdy && v) begin
                    e_load[c + 1]  = 1'b1;
                    e_hinit[c + 1] = first;
                    for (int k = 0; k < ROUNDS; k++) begin
                        e_en[c + 2 + k]  = 1'b1;
                        e_idx[c + 2 + k] = k;
                    end
                    e_upd[c + ROUNDS + 2] = 1'b1;
                    free_at = c + ROUNDS + 3;
                    if (l) done_at = c + ROUNDS + 3;
                    first = l;
                end
                if (e_upd[c]) cnt++;
                if (exp_dv && a) begin
                    done_at = -1;
                    cnt     = 0;
                    free_at = c + 1;
                    first   = 1'b1;
                end
            end
        end
        drive(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
- Sequencing controller for the SHA-256 compression datapath.
- Accepts 512-bit padded blocks from the padder via a valid/ready handshake, then loads the message schedule.
- Steps the datapath through ROUNDS compression rounds, commands hash-state init/update, chains multi-block messages, and holds the final digest-valid flag until it is acknowledged.
- Sits between the padder output and the message-schedule/compression core.

Parameters:
ROUNDS, 64, compression rounds per block; must be ≤ 2^RW.
RW, 6, width of the round index.
CNTW, 16, width of the processed-block counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
blk_valid  input  1  padded 512-bit block available from padder
blk_last  input  1  qualifies blk_valid: block is final block of message
blk_ready  output  1  controller can accept a block this cycle
pad_ovf  input  1  padder overflow/error indication
core_load  output  1  one-cycle pulse: latch block into W[0..15], load working vars a..h from H
h_init  output  1  one-cycle pulse, coincident with core_load on first block: load H with IV first
core_en  output  1  round advance enable to compression core
round_idx  output  RW  current round number, selects K[t]/W[t]
h_update  output  1  one-cycle pulse: H[i] <= H[i] + working var
digest_valid  output  1  final H is the message digest
digest_ack  input  1  consumer has taken digest
busy  output  1  high in any state except IDLE
err  output  1  sticky error flag
blk_cnt  output  CNTW  blocks processed in current message

Behaviour:
- Clock/reset: one clock domain, clk. Reset is asynchronous and active-high (rst); deassertion is synchronised externally. All state flops clear immediately on rst.
- Reset values:
  - state = IDLE, first_blk = 1.
  - All outputs 0 except blk_ready = 1.
  - rst mid-operation aborts the current message; no h_update or digest_valid is produced.
- States: IDLE, LOAD, ROUND, UPDATE, DONE, ERR.
- IDLE:
  - blk_ready = 1.
  - Handshake occurs when blk_valid & blk_ready.
  - On handshake: latch last_q = blk_last, go to LOAD.
  - blk_valid with blk_ready low is ignored; the padder holds the block.
- LOAD (1 cycle):
  - core_load = 1, and h_init = first_blk.
  - round_idx <= 0, then go to ROUND.
- ROUND:
  - core_en = 1 every cycle.
  - round_idx increments each cycle, 0..ROUNDS-1; exactly ROUNDS cycles.
  - At round_idx == ROUNDS-1, go to UPDATE; round_idx wraps to 0 with no extra enable.
- UPDATE (1 cycle):
  - h_update = 1.
  - blk_cnt saturating increment.
  - first_blk <= last_q.
  - Next state is DONE if last_q, else IDLE. The next block is accepted with no gap cycle.
- DONE:
  - digest_valid = 1, held until digest_ack is sampled high.
  - On ack: go to IDLE, blk_cnt <= 0, first_blk = 1.
  - blk_ready = 0 in DONE, so a new message cannot overwrite H before it is acked.
- Latency: handshake at cycle T gives:
  - core_load at T+1
  - core_en at T+2..T+ROUNDS+1
  - h_update at T+ROUNDS+2
  - digest_valid from T+ROUNDS+3
  - Block throughput is ROUNDS+3 cycles.
- ERR:
  - Entered from any non-reset state when pad_ovf = 1; this takes priority over all other transitions in that cycle.
  - err = 1 and blk_ready = 0; no further core_en, h_update or digest_valid.
  - Left only by rst.
  - pad_ovf in the same cycle as a handshake: the block is not accepted and the controller goes to ERR.
- Simultaneous digest_ack and blk_valid in DONE: ack is consumed, the FSM goes to IDLE, and the block is accepted in the following cycle.
- digest_ack outside DONE is ignored.
- blk_last is sampled only at the handshake.
- Counter rules:
  - round_idx arithmetic is modulo 2^RW.
  - blk_cnt saturates at 2^CNTW-1.
- Outputs are registered (Moore) except blk_ready, which is decoded from the state register only. No combinational path exists from inputs to outputs.

Test Plan:
1. Single block "abc": rst pulse, blk_valid = 1 with blk_last = 1 accepted at T=5 -> core_load and h_init at 6; core_en at 7..70 with round_idx 0..63; h_update at 71; digest_valid from 72; blk_cnt = 1; digest_ack at 80 -> IDLE at 81, blk_ready = 1, blk_cnt = 0.
2. Two-block message: block 0 with blk_last = 0 at T, block 1 with blk_last = 1 held valid -> block 1 accepted at T+67 (IDLE); its core_load has h_init = 0; exactly two h_update pulses; one digest_valid; blk_cnt = 2.
3. Back-pressure: blk_valid asserted during ROUND and DONE -> blk_ready = 0; no extra core_load; digest_valid stays high for 10 unacked cycles.
4. Padder overflow: pad_ovf pulse at round_idx = 20 -> next cycle err = 1, core_en = 0, busy = 1; no h_update; err persists until rst.
5. Async reset mid-ROUND at round_idx = 37, asserted between clock edges -> outputs clear immediately without a clock edge; after release, a fresh single-block message produces h_init = 1 and a correct 67-cycle latency.
6. Ack/valid collision: digest_ack and a new blk_valid in the same DONE cycle -> IDLE the next cycle, new block accepted one cycle later, h_init = 1.
